// File: rtl/i2c_write_master.sv
// I2C write-only master: START, 7-bit address + W, register byte, data byte,
// ACK check after each byte, STOP. Each protocol slot is 4*DIV clk cycles
// split into four quarters; SCL is low in Q0..Q1 and high in Q2..Q3.
module i2c_write_master #(
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [6:0] slave_address,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic       busy,
    output logic       done,
    output logic       nack_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ACK1, S_REG, S_ACK2, S_DATA, S_ACK3, S_STOP
    } state_e;

    localparam logic [7:0] QMAX = 8'(DIV - 1);

    state_e     state_q, state_d;
    logic [7:0] qcnt_q, qcnt_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] bit_q, bit_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] data_q, data_d;
    logic       nack_sticky_q, nack_sticky_d;
    logic       nack_err_q, nack_err_d;
    logic       done_q, done_d;

    logic       quarter_end, sample_pt, slot_end, in_ack;
    logic [7:0] tx_byte;
    logic       tx_bit;

    assign quarter_end = (qcnt_q == QMAX);
    assign sample_pt   = quarter_end && (phase_q == 2'd2);
    assign slot_end    = quarter_end && (phase_q == 2'd3);
    assign in_ack      = (state_q == S_ACK1) || (state_q == S_ACK2) || (state_q == S_ACK3);

    // State and datapath registers, all cleared asynchronously.
    // NOTE: operand latches are ordinary flops, so they are reset with everything
    // else; nothing here is a RAM that would need to stay reset-free.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            qcnt_q        <= '0;
            phase_q       <= '0;
            bit_q         <= '0;
            addr_q        <= '0;
            reg_q         <= '0;
            data_q        <= '0;
            nack_sticky_q <= 1'b0;
            nack_err_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge
            // value of the others, regardless of statement order.
            state_q       <= state_d;
            qcnt_q        <= qcnt_d;
            phase_q       <= phase_d;
            bit_q         <= bit_d;
            addr_q        <= addr_d;
            reg_q         <= reg_d;
            data_q        <= data_d;
            nack_sticky_q <= nack_sticky_d;
            nack_err_q    <= nack_err_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic: transitions happen only at slot boundaries (or on start in IDLE).
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_START;
            S_START: if (slot_end) state_d = S_ADDR;
            S_ADDR:  if (slot_end && bit_q == 3'd7) state_d = S_ACK1;
            S_ACK1:  if (slot_end) state_d = nack_sticky_q ? S_STOP : S_REG;
            S_REG:   if (slot_end && bit_q == 3'd7) state_d = S_ACK2;
            S_ACK2:  if (slot_end) state_d = nack_sticky_q ? S_STOP : S_DATA;
            S_DATA:  if (slot_end && bit_q == 3'd7) state_d = S_ACK3;
            S_ACK3:  if (slot_end) state_d = S_STOP;
            S_STOP:  if (slot_end) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Quarter/phase/bit timing, operand capture, ACK sampling and completion flags.
    always_comb begin
        qcnt_d        = qcnt_q;
        phase_d       = phase_q;
        bit_d         = bit_q;
        addr_d        = addr_q;
        reg_d         = reg_q;
        data_d        = data_q;
        nack_sticky_d = nack_sticky_q;
        nack_err_d    = nack_err_q;
        done_d        = 1'b0;

        if (state_q == S_IDLE) begin
            qcnt_d  = '0;
            phase_d = '0;
            bit_d   = '0;
            if (start) begin
                addr_d        = slave_address;
                reg_d         = reg_addr;
                data_d        = wdata;
                nack_sticky_d = 1'b0;
                nack_err_d    = 1'b0;
            end
        end else begin
            qcnt_d = quarter_end ? 8'd0 : qcnt_q + 8'd1;
            if (quarter_end) phase_d = phase_q + 2'd1;
            if (slot_end) begin
                if (state_q == S_ADDR || state_q == S_REG || state_q == S_DATA) begin
                    bit_d = bit_q + 3'd1;
                end else begin
                    bit_d = '0;
                end
            end
            // Single ACK sample on the last clk of Q2, while SCL is high.
            if (in_ack && sample_pt && sda_in) nack_sticky_d = 1'b1;
            if (state_q == S_STOP && slot_end) begin
                done_d     = 1'b1;
                nack_err_d = nack_sticky_q;
            end
        end
    end

    // Bus outputs decoded from state and phase; SDA only moves at slot entry or
    // at the START/STOP mid-slot edges while SCL is high.
    always_comb begin
        scl     = 1'b1;
        sda_oe  = 1'b0;
        tx_byte = {addr_q, 1'b0};
        if (state_q == S_REG)  tx_byte = reg_q;
        if (state_q == S_DATA) tx_byte = data_q;
        tx_bit = tx_byte[3'd7 - bit_q];
        unique case (state_q)
            S_IDLE:  ;
            S_START: sda_oe = phase_q[1];
            S_ADDR, S_REG, S_DATA: begin
                scl    = phase_q[1];
                sda_oe = ~tx_bit;
            end
            S_ACK1, S_ACK2, S_ACK3: scl = phase_q[1];
            S_STOP: begin
                scl    = phase_q[1];
                sda_oe = (phase_q != 2'd3);
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign nack_err = nack_err_q;

endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench for i2c_write_master: three instances (DIV = 4, 1, 255) share
// one stimulus set and one bus monitor/slave model through a selector.
module tb_i2c_write_master;

    localparam int DIVS [3] = '{4, 1, 255};

    typedef struct {
        int   cycles;
        int   dones;
        logic nack_done;
        logic busy_done;
        logic busy_start;
        logic nack_start;
    } result_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [6:0] slave_address;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic [1:0] sel;

    logic       start_w  [3];
    logic       scl_w    [3];
    logic       sda_oe_w [3];
    logic       sda_in_w [3];
    logic       busy_w   [3];
    logic       done_w   [3];
    logic       nack_w   [3];

    logic       slave_pull;
    logic       scl_v, sda_oe_v, busy_v, done_v, nack_v;

    int         n_cmp = 0;
    int         n_bad = 0;

    // monitor state
    logic       prev_scl, prev_sda;
    logic [7:0] mon_cur;
    int         bit_idx, byte_idx, start_cnt, stop_cnt;
    int         nack_at;
    logic [7:0] byte_log [$];

    always #5 clk = ~clk;

    assign start_w[0] = start && (sel == 2'd0);
    assign start_w[1] = start && (sel == 2'd1);
    assign start_w[2] = start && (sel == 2'd2);
    assign sda_in_w[0] = ~sda_oe_w[0] & ~(slave_pull && sel == 2'd0);
    assign sda_in_w[1] = ~sda_oe_w[1] & ~(slave_pull && sel == 2'd1);
    assign sda_in_w[2] = ~sda_oe_w[2] & ~(slave_pull && sel == 2'd2);

    assign scl_v    = scl_w[sel];
    assign sda_oe_v = sda_oe_w[sel];
    assign busy_v   = busy_w[sel];
    assign done_v   = done_w[sel];
    assign nack_v   = nack_w[sel];

    i2c_write_master #(.DIV(4)) u_div4 (
        .clk(clk), .resetn(resetn), .start(start_w[0]), .slave_address(slave_address),
        .reg_addr(reg_addr), .wdata(wdata), .scl(scl_w[0]), .sda_oe(sda_oe_w[0]),
        .sda_in(sda_in_w[0]), .busy(busy_w[0]), .done(done_w[0]), .nack_err(nack_w[0])
    );
    i2c_write_master #(.DIV(1)) u_div1 (
        .clk(clk), .resetn(resetn), .start(start_w[1]), .slave_address(slave_address),
        .reg_addr(reg_addr), .wdata(wdata), .scl(scl_w[1]), .sda_oe(sda_oe_w[1]),
        .sda_in(sda_in_w[1]), .busy(busy_w[1]), .done(done_w[1]), .nack_err(nack_w[1])
    );
    i2c_write_master #(.DIV(255)) u_div255 (
        .clk(clk), .resetn(resetn), .start(start_w[2]), .slave_address(slave_address),
        .reg_addr(reg_addr), .wdata(wdata), .scl(scl_w[2]), .sda_oe(sda_oe_w[2]),
        .sda_in(sda_in_w[2]), .busy(busy_w[2]), .done(done_w[2]), .nack_err(nack_w[2])
    );

    // Bus monitor + slave: counts START/STOP conditions (any SDA change while SCL
    // stays high), captures bytes at SCL rising edges, and pulls SDA low for the
    // ACK slot of every byte except the one numbered nack_at (1..3).
    always @(negedge clk) begin
        logic sda_now;
        if (!resetn) begin
            prev_scl   = 1'b1;
            prev_sda   = 1'b1;
            bit_idx    = 0;
            byte_idx   = 0;
            slave_pull = 1'b0;
            start_cnt  = 0;
            stop_cnt   = 0;
        end else begin
            sda_now = ~sda_oe_v & ~slave_pull;
            if (prev_scl && scl_v && prev_sda && !sda_now) begin
                start_cnt++;
                bit_idx  = 0;
                byte_idx = 0;
            end else if (prev_scl && scl_v && !prev_sda && sda_now) begin
                stop_cnt++;
            end else if (!prev_scl && scl_v) begin
                if (bit_idx < 8) begin
                    mon_cur = {mon_cur[6:0], sda_now};
                    bit_idx++;
                    if (bit_idx == 8) byte_log.push_back(mon_cur);
                end else begin
                    bit_idx = 0;
                    byte_idx++;
                end
            end else if (prev_scl && !scl_v) begin
                slave_pull = (bit_idx == 8) && (byte_idx + 1 != nack_at);
            end
            prev_scl = scl_v;
            prev_sda = ~sda_oe_v & ~slave_pull;
        end
    end

    // Drives one transaction on instance s and measures it. Cycle n counts clk
    // periods from START entry; start is re-pulsed with other operands at n == inject.
    task automatic run_txn(input logic [1:0] s, input logic [6:0] a, input logic [7:0] r,
                           input logic [7:0] d, input int nack_byte, input int inject,
                           output result_t res);
        int lim;
        lim = 120 * DIVS[s] + 20;
        res.cycles = -1;
        res.dones  = 0;
        res.nack_done = 1'bx;
        res.busy_done = 1'bx;
        sel = s;
        nack_at = nack_byte;
        repeat (2) @(negedge clk);
        byte_log.delete();
        start_cnt = 0;
        stop_cnt  = 0;
        slave_address = a;
        reg_addr = r;
        wdata = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        res.busy_start = busy_v;
        res.nack_start = nack_v;
        for (int n = 1; n <= lim; n++) begin
            @(negedge clk);
            if (n == inject) begin
                start = 1'b1;
                slave_address = 7'h7F;
                reg_addr = 8'hFF;
                wdata = 8'h00;
            end else begin
                start = 1'b0;
            end
            if (done_v) begin
                res.dones++;
                if (res.cycles < 0) begin
                    res.cycles = n;
                    res.nack_done = nack_v;
                    res.busy_done = busy_v;
                end
            end
            if (res.cycles >= 0 && n >= res.cycles + 8 * DIVS[s]) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            n_cmp += 5;
            if (scl_w[i] !== 1'b1) begin n_bad++; $display("FAIL reset_scl[%0d]: got %b want 1", i, scl_w[i]); end
            if (sda_oe_w[i] !== 1'b0) begin n_bad++; $display("FAIL reset_sda_oe[%0d]: got %b want 0", i, sda_oe_w[i]); end
            if (busy_w[i] !== 1'b0) begin n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy_w[i]); end
            if (done_w[i] !== 1'b0) begin n_bad++; $display("FAIL reset_done[%0d]: got %b want 0", i, done_w[i]); end
            if (nack_w[i] !== 1'b0) begin n_bad++; $display("FAIL reset_nack[%0d]: got %b want 0", i, nack_w[i]); end
        end
    endtask

    // Full successful write on instance s: 0x4A, 0x18, 0x14 on the bus, done at 116*DIV.
    task automatic test_basic_write(input logic [1:0] s);
        result_t res;
        run_txn(s, 7'h25, 8'h18, 8'h14, 0, -1, res);
        n_cmp += 9;
        if (res.busy_start !== 1'b1) begin n_bad++; $display("FAIL basic_busy_start div%0d: got %b want 1", DIVS[s], res.busy_start); end
        if (res.cycles != 116 * DIVS[s]) begin n_bad++; $display("FAIL basic_latency div%0d: got %0d want %0d", DIVS[s], res.cycles, 116 * DIVS[s]); end
        if (res.dones != 1) begin n_bad++; $display("FAIL basic_done_count div%0d: got %0d want 1", DIVS[s], res.dones); end
        if (res.busy_done !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done div%0d: got %b want 0", DIVS[s], res.busy_done); end
        if (res.nack_done !== 1'b0) begin n_bad++; $display("FAIL basic_nack div%0d: got %b want 0", DIVS[s], res.nack_done); end
        if (byte_log.size() != 3) begin n_bad++; $display("FAIL basic_byte_count div%0d: got %0d want 3", DIVS[s], byte_log.size()); end
        else if (byte_log[0] !== 8'h4A || byte_log[1] !== 8'h18 || byte_log[2] !== 8'h14) begin
            n_bad++; $display("FAIL basic_bytes div%0d: got %h %h %h want 4a 18 14", DIVS[s], byte_log[0], byte_log[1], byte_log[2]);
        end
        if (start_cnt != 1) begin n_bad++; $display("FAIL basic_start_cond div%0d: got %0d want 1", DIVS[s], start_cnt); end
        if (stop_cnt != 1) begin n_bad++; $display("FAIL basic_stop_cond div%0d: got %0d want 1", DIVS[s], stop_cnt); end
        if (busy_v !== 1'b0) begin n_bad++; $display("FAIL basic_idle_after div%0d: busy got %b want 0", DIVS[s], busy_v); end
    endtask

    // Address NACK: STOP right after ACK1, done at 11 slots, only the address byte seen.
    task automatic test_nack_addr();
        result_t res;
        run_txn(2'd0, 7'h25, 8'h18, 8'h14, 1, -1, res);
        n_cmp += 5;
        if (res.cycles != 44 * 4) begin n_bad++; $display("FAIL nack_addr_latency: got %0d want %0d", res.cycles, 44 * 4); end
        if (res.nack_done !== 1'b1) begin n_bad++; $display("FAIL nack_addr_flag: got %b want 1", res.nack_done); end
        if (byte_log.size() != 1) begin n_bad++; $display("FAIL nack_addr_byte_count: got %0d want 1", byte_log.size()); end
        else if (byte_log[0] !== 8'h4A) begin n_bad++; $display("FAIL nack_addr_byte: got %h want 4a", byte_log[0]); end
        if (stop_cnt != 1) begin n_bad++; $display("FAIL nack_addr_stop_cond: got %0d want 1", stop_cnt); end
    endtask

    // Data NACK: all bytes sent, done at 116*DIV, flag set; next start clears it.
    task automatic test_nack_data();
        result_t res;
        run_txn(2'd0, 7'h25, 8'h18, 8'h14, 3, -1, res);
        n_cmp += 4;
        if (res.cycles != 464) begin n_bad++; $display("FAIL nack_data_latency: got %0d want 464", res.cycles); end
        if (res.nack_done !== 1'b1) begin n_bad++; $display("FAIL nack_data_flag: got %b want 1", res.nack_done); end
        if (byte_log.size() != 3) begin n_bad++; $display("FAIL nack_data_byte_count: got %0d want 3", byte_log.size()); end
        if (nack_v !== 1'b1) begin n_bad++; $display("FAIL nack_data_sticky_idle: got %b want 1", nack_v); end
        run_txn(2'd0, 7'h25, 8'h18, 8'h14, 0, -1, res);
        n_cmp += 2;
        if (res.nack_start !== 1'b0) begin n_bad++; $display("FAIL nack_cleared_on_start: got %b want 0", res.nack_start); end
        if (res.nack_done !== 1'b0) begin n_bad++; $display("FAIL nack_after_clean_txn: got %b want 0", res.nack_done); end
    endtask

    // start during DATA is ignored; start in the last STOP cycle is not accepted.
    task automatic test_back_to_back();
        result_t res;
        run_txn(2'd0, 7'h25, 8'h18, 8'h14, 0, 309, res);
        n_cmp += 3;
        if (res.dones != 1) begin n_bad++; $display("FAIL b2b_busy_done_count: got %0d want 1", res.dones); end
        if (res.cycles != 464) begin n_bad++; $display("FAIL b2b_busy_latency: got %0d want 464", res.cycles); end
        if (byte_log.size() != 3) begin n_bad++; $display("FAIL b2b_busy_byte_count: got %0d want 3", byte_log.size()); end
        else if (byte_log[0] !== 8'h4A || byte_log[1] !== 8'h18 || byte_log[2] !== 8'h14) begin
            n_bad++; $display("FAIL b2b_busy_bytes: got %h %h %h want 4a 18 14", byte_log[0], byte_log[1], byte_log[2]);
        end
        run_txn(2'd0, 7'h25, 8'h18, 8'h14, 0, 463, res);
        n_cmp += 3;
        if (res.dones != 1) begin n_bad++; $display("FAIL b2b_stop_done_count: got %0d want 1", res.dones); end
        if (busy_v !== 1'b0) begin n_bad++; $display("FAIL b2b_stop_not_accepted: busy got %b want 0", busy_v); end
        if (start_cnt != 1) begin n_bad++; $display("FAIL b2b_stop_start_cond: got %0d want 1", start_cnt); end
    endtask

    // Reset in the middle of REG bit 3 (slot 14, Q1): bus released asynchronously,
    // no done, and the next start right after reset release completes normally.
    task automatic test_reset_abort();
        int dones;
        sel = 2'd0;
        nack_at = 0;
        repeat (2) @(negedge clk);
        slave_address = 7'h25;
        reg_addr = 8'h18;
        wdata = 8'h14;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (230) @(negedge clk);
        n_cmp += 2;
        if (scl_v !== 1'b0) begin n_bad++; $display("FAIL abort_pre_scl: got %b want 0", scl_v); end
        if (busy_v !== 1'b1) begin n_bad++; $display("FAIL abort_pre_busy: got %b want 1", busy_v); end
        #2 resetn = 1'b0;
        #1;
        n_cmp += 3;
        if (scl_v !== 1'b1) begin n_bad++; $display("FAIL abort_scl: got %b want 1", scl_v); end
        if (sda_oe_v !== 1'b0) begin n_bad++; $display("FAIL abort_sda_oe: got %b want 0", sda_oe_v); end
        if (busy_v !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy_v); end
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_v) dones++;
        end
        resetn = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done_v) dones++;
        end
        n_cmp++;
        if (dones != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", dones); end
        begin
            result_t res;
            run_txn(2'd0, 7'h5A, 8'hC3, 8'h7E, 0, -1, res);
            n_cmp += 3;
            if (res.busy_start !== 1'b1) begin n_bad++; $display("FAIL post_abort_accept: got %b want 1", res.busy_start); end
            if (res.cycles != 464) begin n_bad++; $display("FAIL post_abort_latency: got %0d want 464", res.cycles); end
            if (byte_log.size() != 3) begin n_bad++; $display("FAIL post_abort_byte_count: got %0d want 3", byte_log.size()); end
            else if (byte_log[0] !== 8'hB4 || byte_log[1] !== 8'hC3 || byte_log[2] !== 8'h7E) begin
                n_bad++; $display("FAIL post_abort_bytes: got %h %h %h want b4 c3 7e", byte_log[0], byte_log[1], byte_log[2]);
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        start = 1'b0;
        slave_address = '0;
        reg_addr = '0;
        wdata = '0;
        sel = 2'd0;
        nack_at = 0;
        slave_pull = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        resetn = 1'b1;
        test_basic_write(2'd0);
        test_nack_addr();
        test_nack_data();
        test_back_to_back();
        test_reset_abort();
        test_basic_write(2'd1);
        test_basic_write(2'd2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_write_master.md
I2C_WRITE_MASTER -- requirements
Module: i2c_write_master

Interface
Parameter:
REQ-001 DIV, default 4: number of clk cycles per SCL quarter-period; legal range 1..255; SCL period = 4*DIV clk cycles.

Ports:
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request to begin a write transaction.
REQ-005 slave_address  in  7  target address, MSB first on the bus.
REQ-006 reg_addr  in  8  register address byte.
REQ-007 wdata  in  8  data byte to write.
REQ-008 scl  out  1  I2C clock, push-pull.
REQ-009 sda_oe  out  1  open-drain SDA control: 1 = pull SDA low, 0 = release (bus reads 1).
REQ-010 sda_in  in  1  sampled SDA bus level, used for ACK detection only.
REQ-011 busy  out  1  high from accepted start until STOP completes.
REQ-012 done  out  1  one-cycle pulse when the transaction ends, whether by success or NACK.
REQ-013 nack_err  out  1  set with done if any ACK slot read 1; cleared on the next accepted start.

Function
REQ-014 States SHALL be IDLE, START, ADDR, ACK1, REG, ACK2, DATA, ACK3, STOP.
REQ-015 In IDLE, start=1 SHALL latch slave_address, reg_addr and wdata, set busy, clear nack_err, and enter START on the next cycle.
REQ-016 start while busy=1 SHALL be ignored; latched operands SHALL NOT change.
REQ-017 A free-running quarter counter (0..DIV-1) plus a 2-bit phase index Q0..Q3 SHALL time every non-IDLE state; each state lasts exactly 4*DIV clk cycles, and each bit slot exactly 4*DIV.
REQ-018 START: scl=1 for all of Q0..Q3; sda_oe=0 in Q0..Q1 and 1 in Q2..Q3, giving an SDA H->L edge while SCL is high.
REQ-019 Bit slots (ADDR, REG, DATA, ACKx): scl=0 in Q0..Q1 and 1 in Q2..Q3; SDA SHALL change only at entry to Q0.
REQ-020 ADDR SHALL send 8 bits: slave_address[6:0] MSB first, then R/W=0. REG SHALL send reg_addr[7:0] MSB first, and DATA SHALL send wdata[7:0] MSB first; sda_oe = ~bit.
REQ-021 ACK1/2/3: sda_oe=0 for the slot; sda_in SHALL be sampled once, on the last clk of Q2.
REQ-022 Sample 0 (ACK) SHALL advance ACK1->REG, ACK2->DATA, ACK3->STOP; sample 1 (NACK) SHALL set a sticky NACK flag and go directly to STOP.
REQ-023 STOP: scl=0 in Q0..Q1 and 1 in Q2..Q3; sda_oe=1 in Q0..Q2 and 0 in Q3, giving an SDA L->H edge while SCL is high.
REQ-024 At the end of STOP, the block SHALL return to IDLE, pulse done for 1 cycle, drop busy in the same cycle, and drive nack_err from the sticky flag.
REQ-025 Total successful transaction = 1+8+1+8+1+8+1+1 = 29 slots = 116*DIV clk cycles from START entry to done.
REQ-026 start asserted in the same cycle as done/IDLE return SHALL NOT be accepted; acceptance requires state IDLE at the sampling edge.
REQ-027 In IDLE: scl=1, sda_oe=0, busy=0, done=0.

Reset
REQ-028 resetn=0 SHALL force immediately, independent of clk: state IDLE, scl=1, sda_oe=0, busy=0, done=0, nack_err=0, counters 0, latched operands 0.
REQ-029 Reset asserted mid-transaction SHALL abort it with no STOP generated and no done pulse; the bus is released at once.
REQ-030 After resetn rises, the first start SHALL be accepted on the first clk edge with start=1.

Verification
REQ-031 DIV=4, addr=0x25, reg=0x18, data=0x14, slave acks all -> SDA bits 0x4A, 0x18, 0x14 seen at SCL rising edges; done after 464 cycles; nack_err=0.
REQ-032 Same operands, sda_in=1 in ACK1 -> STOP follows directly; done 11 slots (44*DIV cycles) after START entry; nack_err=1; REG and DATA are never sent.
REQ-033 NACK only in ACK3 -> all 3 bytes sent; done at 116*DIV cycles; nack_err=1; next start clears nack_err.
REQ-034 start pulsed again during DATA with different operands -> ignored; bus shows the original bytes; exactly one done pulse.
REQ-035 resetn low during REG bit 3 -> scl=1, sda_oe=0, busy=0 asynchronously; no done pulse; new start afterwards completes normally.
REQ-036 Protocol checker: SDA never changes while SCL=1 except for the START H->L and STOP L->H edges; DIV=1 and DIV=255 both pass REQ-031.
